// File: rtl/sam_sequencer.sv
// Hardwired Moore control unit for the SAM accumulator datapath.
// Sequences fetch/decode/execute, runs the REQUEST/WAIT memory handshake and guards it with a watchdog.
module sam_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WAIT,
    input  logic        IR15,
    input  logic        AC15,
    input  logic        IR14,
    output logic [21:0] b,
    output logic [4:0]  state,
    output logic        err
);

    typedef enum logic [4:0] {
        S_RST = 5'd0,
        S_F0  = 5'd1,
        S_F1  = 5'd2,
        S_F2  = 5'd3,
        S_F3  = 5'd4,
        S_DEC = 5'd5,
        S_RD1 = 5'd6,
        S_RD2 = 5'd7,
        S_LD1 = 5'd8,
        S_AD1 = 5'd9,
        S_EX2 = 5'd10,
        S_EX3 = 5'd11,
        S_ST1 = 5'd12,
        S_ST2 = 5'd13,
        S_ST3 = 5'd14,
        S_ST4 = 5'd15,
        S_BR1 = 5'd16,
        S_ERR = 5'd31
    } state_t;

    localparam logic [7:0] WD_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [21:0] b_q, b_d;
    logic        err_q, err_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        in_wait_state;
    logic        timeout;

    // Control word is a pure function of the state, so it can be registered from the next state.
    function automatic logic [21:0] decode(input state_t s);
        case (s)
            S_RST:        decode = 22'h000040;
            S_F0:         decode = 22'h200400;
            S_F1, S_RD1:  decode = 22'h00200C;
            S_F2:         decode = 22'h00220C;
            S_F3:         decode = 22'h080820;
            S_DEC:        decode = 22'h100400;
            S_RD2:        decode = 22'h00228C;
            S_LD1:        decode = 22'h014000;
            S_AD1:        decode = 22'h038000;
            S_EX2:        decode = 22'h000001;
            S_EX3:        decode = 22'h040000;
            S_ST1:        decode = 22'h000002;
            S_ST2:        decode = 22'h000100;
            S_ST3, S_ST4: decode = 22'h003004;
            S_BR1:        decode = 22'h100010;
            default:      decode = 22'h000000;
        endcase
    endfunction

    assign in_wait_state = (state_q == S_F2) || (state_q == S_RD2) || (state_q == S_ST4);
    assign timeout       = WAIT && (wcnt_q == WD_LIMIT);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        wcnt_d  = wcnt_q;

        case (state_q)
            S_RST: state_d = S_F0;
            S_F0:  state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = !WAIT ? S_F3 : (timeout ? S_ERR : S_F2);
            S_F3:  state_d = S_DEC;
            S_DEC: begin
                case ({IR15, IR14})
                    2'b01:   state_d = S_ST1;
                    2'b11:   state_d = AC15 ? S_BR1 : S_F0;
                    default: state_d = S_RD1;
                endcase
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                if (!WAIT)        state_d = IR15 ? S_AD1 : S_LD1;
                else if (timeout) state_d = S_ERR;
            end
            S_LD1: state_d = S_EX2;
            S_AD1: state_d = S_EX2;
            S_EX2: state_d = S_EX3;
            S_EX3: state_d = S_F0;
            S_ST1: state_d = S_ST2;
            S_ST2: state_d = S_ST3;
            S_ST3: state_d = S_ST4;
            S_ST4: state_d = !WAIT ? S_F0 : (timeout ? S_ERR : S_ST4);
            S_BR1: state_d = S_F0;
            S_ERR: state_d = S_ERR;
            default: state_d = S_RST;
        endcase

        // Watchdog counts busy cycles of the current access and restarts at each request state.
        if (in_wait_state && WAIT && (wcnt_q != 8'hFF))
            wcnt_d = wcnt_q + 8'd1;
        if ((state_d == S_F1) || (state_d == S_RD1) || (state_d == S_ST3))
            wcnt_d = 8'd0;
    end

    always_comb begin
        b_d   = decode(state_d);
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q <= S_RST;
            b_q     <= 22'h000040;
            err_q   <= 1'b0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign b     = b_q;
    assign state = state_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sam_sequencer.sv
// Self-checking bench for sam_sequencer: instruction-level model produces the expected state trace,
// a monitor compares state, control word and err against it on each negedge.
module tb_sam_sequencer;

    localparam int RST = 0,  F0 = 1,  F1 = 2,  F2 = 3,  F3 = 4,  DEC = 5;
    localparam int RD1 = 6,  RD2 = 7,  LD1 = 8,  AD1 = 9,  EX2 = 10, EX3 = 11;
    localparam int ST1 = 12, ST2 = 13, ST3 = 14, ST4 = 15, BR1 = 16, ERR = 31;
    localparam int TIMEOUT = 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        WAIT = 1'b0;
    logic        IR15 = 1'b0;
    logic        AC15 = 1'b0;
    logic        IR14 = 1'b0;
    logic [21:0] b;
    logic [4:0]  state;
    logic        err;

    sam_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst   (rst),
        .WAIT  (WAIT),
        .IR15  (IR15),
        .AC15  (AC15),
        .IR14  (IR14),
        .b     (b),
        .state (state),
        .err   (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int exp_q[$];
    bit noise  = 1'b0;

    function automatic logic [21:0] exp_b(input int s);
        case (s)
            RST:      return 22'h000040;
            F0:       return 22'h200400;
            F1, RD1:  return 22'h00200C;
            F2:       return 22'h00220C;
            F3:       return 22'h080820;
            DEC:      return 22'h100400;
            RD2:      return 22'h00228C;
            LD1:      return 22'h014000;
            AD1:      return 22'h038000;
            EX2:      return 22'h000001;
            EX3:      return 22'h040000;
            ST1:      return 22'h000002;
            ST2:      return 22'h000100;
            ST3, ST4: return 22'h003004;
            BR1:      return 22'h100010;
            default:  return 22'h000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, expv);
        end
    endtask

    // Monitor: each negedge shows the state reached at the preceding posedge.
    always @(negedge clk) begin
        int e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("state", 32'(state), e);
            check("b", 32'(b), 32'(exp_b(e)));
            check("err", 32'(err), (e == ERR) ? 32'd1 : 32'd0);
        end
        cycle++;
    end

    // One clock: drive inputs, let the posedge sample them, record the state that must follow.
    task automatic step(input logic r, input logic w, input int nxt);
        rst  = r;
        WAIT = w;
        @(posedge clk);
        exp_q.push_back(nxt);
        #1;
    endtask

    // WAIT value in states that must ignore it.
    function automatic logic nz();
        return noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic mem_wait(input int ws, input int n, input int nxt);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, ws);
        step(1'b0, 1'b0, nxt);
    endtask

    // One instruction starting in F0; wf/wm are the busy cycles of the fetch and operand accesses.
    task automatic run_instr(input logic [1:0] op, input logic ac, input int wf, input int wm);
        IR15 = op[1];
        IR14 = op[0];
        AC15 = ac;
        step(1'b0, nz(), F1);
        step(1'b0, nz(), F2);
        mem_wait(F2, wf, F3);
        step(1'b0, nz(), DEC);
        case (op)
            2'b00, 2'b10: begin
                step(1'b0, nz(), RD1);
                step(1'b0, nz(), RD2);
                mem_wait(RD2, wm, op[1] ? AD1 : LD1);
                step(1'b0, nz(), EX2);
                step(1'b0, nz(), EX3);
                step(1'b0, nz(), F0);
            end
            2'b01: begin
                step(1'b0, nz(), ST1);
                step(1'b0, nz(), ST2);
                step(1'b0, nz(), ST3);
                step(1'b0, nz(), ST4);
                mem_wait(ST4, wm, F0);
            end
            default: begin
                if (ac) begin
                    step(1'b0, nz(), BR1);
                    step(1'b0, nz(), F0);
                end else begin
                    step(1'b0, nz(), F0);
                end
            end
        endcase
    endtask

    // Walk from F0 into the wait state of the chosen access (0: fetch, 1: read, 2: store).
    task automatic goto_wait(input int where);
        IR15 = 1'b0;
        IR14 = (where == 2);
        step(1'b0, 1'b0, F1);
        step(1'b0, 1'b0, F2);
        if (where == 0) return;
        step(1'b0, 1'b0, F3);
        step(1'b0, 1'b0, DEC);
        if (where == 1) begin
            step(1'b0, 1'b0, RD1);
            step(1'b0, 1'b0, RD2);
        end else begin
            step(1'b0, 1'b0, ST1);
            step(1'b0, 1'b0, ST2);
            step(1'b0, 1'b0, ST3);
            step(1'b0, 1'b0, ST4);
        end
    endtask

    // Memory stuck busy: TIMEOUT busy cycles in the wait state, then ERR until reset.
    task automatic stuck_access(input int where);
        int ws;
        ws = (where == 0) ? F2 : (where == 1) ? RD2 : ST4;
        goto_wait(where);
        for (int k = 0; k < TIMEOUT - 1; k++) step(1'b0, 1'b1, ws);
        step(1'b0, 1'b1, ERR);
        for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom_range(0, 1)), ERR);
        step(1'b1, 1'($urandom_range(0, 1)), RST);
        step(1'b0, 1'($urandom_range(0, 1)), F0);
    endtask

    initial begin
        // Reset held three cycles, then released.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, RST);
        step(1'b0, 1'b0, F0);

        // Directed instructions with quiet WAIT.
        run_instr(2'b00, 1'b0, 0, 0);
        run_instr(2'b10, 1'b0, 0, 3);
        run_instr(2'b01, 1'b0, 0, 0);
        run_instr(2'b11, 1'b1, 0, 0);
        run_instr(2'b11, 1'b0, 0, 0);
        run_instr(2'b00, 1'b0, 3, 3);
        run_instr(2'b01, 1'b1, 2, 3);

        // Watchdog in each wait state.
        stuck_access(0);
        stuck_access(1);
        stuck_access(2);

        // Reset in the middle of a read wait.
        goto_wait(1);
        step(1'b0, 1'b1, RD2);
        step(1'b1, 1'b1, RST);
        step(1'b0, 1'b0, F0);

        // Randomized instruction stream with random busy lengths and noisy WAIT.
        noise = 1'b1;
        for (int i = 0; i < 80; i++) begin
            run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0);
            if ($urandom_range(0, 19) == 0) stuck_access(int'($urandom_range(0, 2)));
        end

        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
